// File: rtl/mips_muldiv_unit.sv
// -----------------------------------------------------------------------------
// mips_muldiv_unit
//
// Iterative multiply/divide unit for the MIPS EX stage. Owns the architectural
// HI/LO registers and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
// A MULT/DIV is accepted in IDLE. It then runs WIDTH shift-add or restoring-
// division iterations in CALC. It applies operand signs and writes HI/LO in FIX.
// MTHI/MTLO write in the accept cycle without becoming busy.
//
// Ports:
//   CLK       clock, all state changes on the rising edge
//   RST       synchronous, active-low reset
//   start     issue request, only looked at while busy=0
//   op        0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO (6,7 ignored)
//   Rdata1    rs operand (multiplicand / dividend / MT source)
//   Rdata2    rt operand (multiplier / divisor)
//   cancel    abort the in-flight operation (flush / exception)
//   busy      high while a MULT/DIV is in flight (EX must stall on it)
//   done      one-cycle pulse after HI/LO receive a MULT/DIV result
//   div_zero  sticky: last completed DIV/DIVU had a zero divisor
//   HIreg     architectural HI
//   LOreg     architectural LO
// -----------------------------------------------------------------------------
module mips_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] Rdata1,
    input  logic [WIDTH-1:0] Rdata2,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] HIreg,
    output logic [WIDTH-1:0] LOreg
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state_reg, state_next;

    // Iteration state
    logic [CNT_W-1:0]   cnt_reg;
    logic [2*WIDTH-1:0] acc_reg;     // mul: {partial product, multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0]   opb_reg;     // mul: |multiplicand|; div: |divisor|
    logic [WIDTH-1:0]   raw_a_reg;   // unmodified dividend, returned in HI on divide by zero
    logic               is_div_reg;
    logic               neg_res_reg; // product / quotient must be negated
    logic               neg_rem_reg; // remainder follows the dividend sign
    logic               div0_reg;

    // Architectural state
    logic               done_reg;
    logic               div_zero_reg;
    logic [WIDTH-1:0]   hi_reg;
    logic [WIDTH-1:0]   lo_reg;

    // ------------------------------------------------------------------
    // Issue decode
    // ------------------------------------------------------------------
    logic issue_ok;
    logic accept;
    logic mthi_accept;
    logic mtlo_accept;

    assign issue_ok    = (state_reg == IDLE) && start && !cancel;
    assign accept      = issue_ok && (op[2] == 1'b0);
    assign mthi_accept = issue_ok && (op == 3'd4);
    assign mtlo_accept = issue_ok && (op == 3'd5);

    // Operand magnitudes and signs; only MULT (0) and DIV (2) are signed.
    logic             signed_op;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    assign signed_op = (op[0] == 1'b0);
    assign a_neg     = signed_op && Rdata1[WIDTH-1];
    assign b_neg     = signed_op && Rdata2[WIDTH-1];
    assign mag_a     = a_neg ? (-Rdata1) : Rdata1;
    assign mag_b     = b_neg ? (-Rdata2) : Rdata2;

    // ------------------------------------------------------------------
    // One iteration of each algorithm
    // ------------------------------------------------------------------
    // Shift-add: conditionally add the multiplicand into the upper half and
    // shift right. The carry out of the add becomes the new top bit.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_step;

    assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
                    + (acc_reg[0] ? {1'b0, opb_reg} : {(WIDTH+1){1'b0}});
    assign mul_step = {mul_sum, acc_reg[WIDTH-1:1]};

    // Restoring division: shift the next dividend bit into the remainder.
    // Then subtract the divisor if it fits. The shifted value needs WIDTH+1
    // bits. The result is always below the divisor, so it fits in WIDTH bits.
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] div_step;

    assign div_shift = acc_reg[2*WIDTH-1:WIDTH-1];
    assign div_diff  = div_shift - {1'b0, opb_reg};
    assign div_ge    = (div_shift >= {1'b0, opb_reg});
    assign div_step  = div_ge ? {div_diff[WIDTH-1:0],  acc_reg[WIDTH-2:0], 1'b1}
                              : {div_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0};

    // ------------------------------------------------------------------
    // Sign fix-up applied in FIX
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] prod_fin;
    logic [WIDTH-1:0]   quo_fin;
    logic [WIDTH-1:0]   rem_fin;

    assign prod_fin = neg_res_reg ? (-acc_reg) : acc_reg;
    assign quo_fin  = neg_res_reg ? (-acc_reg[WIDTH-1:0]) : acc_reg[WIDTH-1:0];
    assign rem_fin  = neg_rem_reg ? (-acc_reg[2*WIDTH-1:WIDTH]) : acc_reg[2*WIDTH-1:WIDTH];

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    logic last_iter;
    logic commit;

    assign last_iter = (cnt_reg == CNT_W'(WIDTH - 1));

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        commit     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = CALC;
                end
            end
            CALC: begin
                if (cancel) begin
                    state_next = IDLE;
                end else if (last_iter) begin
                    state_next = FIX;
                end
            end
            FIX: begin
                // cancel wins over the result write
                state_next = IDLE;
                commit     = !cancel;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and architectural registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RST) begin
            cnt_reg      <= '0;
            acc_reg      <= '0;
            opb_reg      <= '0;
            raw_a_reg    <= '0;
            is_div_reg   <= 1'b0;
            neg_res_reg  <= 1'b0;
            neg_rem_reg  <= 1'b0;
            div0_reg     <= 1'b0;
            done_reg     <= 1'b0;
            div_zero_reg <= 1'b0;
            hi_reg       <= '0;
            lo_reg       <= '0;
        end else begin
            done_reg <= commit;

            if (accept) begin
                cnt_reg     <= '0;
                is_div_reg  <= op[1];
                neg_res_reg <= a_neg ^ b_neg;
                neg_rem_reg <= a_neg;
                div0_reg    <= (Rdata2 == '0);
                raw_a_reg   <= Rdata1;
                if (op[1]) begin
                    acc_reg <= {{WIDTH{1'b0}}, mag_a};
                    opb_reg <= mag_b;
                end else begin
                    acc_reg <= {{WIDTH{1'b0}}, mag_b};
                    opb_reg <= mag_a;
                end
            end else if (state_reg == CALC) begin
                acc_reg <= is_div_reg ? div_step : mul_step;
                cnt_reg <= cnt_reg + CNT_W'(1);
            end

            if (mthi_accept) begin
                hi_reg <= Rdata1;
            end
            if (mtlo_accept) begin
                lo_reg <= Rdata1;
            end

            if (commit) begin
                if (!is_div_reg) begin
                    hi_reg       <= prod_fin[2*WIDTH-1:WIDTH];
                    lo_reg       <= prod_fin[WIDTH-1:0];
                    div_zero_reg <= 1'b0;
                end else if (div0_reg) begin
                    hi_reg       <= raw_a_reg;
                    lo_reg       <= {WIDTH{1'b1}};
                    div_zero_reg <= 1'b1;
                end else begin
                    hi_reg       <= rem_fin;
                    lo_reg       <= quo_fin;
                    div_zero_reg <= 1'b0;
                end
            end
        end
    end

    assign busy     = (state_reg != IDLE);
    assign done     = done_reg;
    assign div_zero = div_zero_reg;
    assign HIreg    = hi_reg;
    assign LOreg    = lo_reg;

endmodule

// File: doc/mips_muldiv_unit.md
Name: mips_muldiv_unit

Overview:
Iterative multiply/divide unit for the MIPS EX stage. It owns the architectural HI/LO registers and executes MULT, MULTU, DIV, DIVU, MTHI and MTLO. EX issues an operation with a start/busy/done handshake. EX reads HIreg/LOreg directly for MFHI/MFLO and must stall while busy=1. The data width is a parameter.

Parameters:
WIDTH, 32, operand and HI/LO width; must be even and >= 4
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; not overridden)

Ports:
CLK  in  1  clock; all state updates on its rising edge
RST  in  1  reset, synchronous, active-low
start  in  1  issue request, sampled only when busy=0
op  in  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6 and 7 reserved
Rdata1  in  WIDTH  rs operand (multiplicand / dividend / MT source)
Rdata2  in  WIDTH  rt operand (multiplier / divisor)
cancel  in  1  abort the in-flight operation (flush/exception)
busy  out  1  high while a MULT/DIV is in flight
done  out  1  one-cycle pulse when HI/LO receive a MULT/DIV result
div_zero  out  1  sticky flag: last completed DIV/DIVU had divisor 0
HIreg  out  WIDTH  architectural HI
LOreg  out  WIDTH  architectural LO

Behaviour:
- Interface: one clock, CLK. RST is synchronous and active-low.
- Reset (RST=0 at a CLK edge) forces: state=IDLE, busy=0, done=0, div_zero=0, HIreg=0, LOreg=0. If reset arrives mid-operation, the operation is discarded.
- State machine has three states: IDLE, CALC, FIX.
- IDLE:
  - start=1 and cancel=0 with op 0-3: latch the operands and op, clear the counter, go to CALC; busy=1 from the next cycle.
  - Signed ops (MULT, DIV) latch magnitudes plus the result/remainder signs.
  - op 4 writes HIreg=Rdata1 at that edge; op 5 writes LOreg=Rdata1. State stays IDLE, busy and done stay 0.
  - op 6 or 7 is ignored.
  - start=1 together with cancel=1 is ignored.
- CALC:
  - Exactly WIDTH edges, one iteration per edge.
  - Multiply: shift-add producing a 2*WIDTH-bit unsigned product.
  - Divide: restoring division producing an unsigned quotient and remainder.
  - After the WIDTH-th iteration, go to FIX.
- FIX (one edge):
  - Apply signs: product negated if the operand signs differ; quotient negated if the operand signs differ; remainder takes the dividend's sign (truncate toward zero).
  - Write HIreg/LOreg, pulse done=1 for the next cycle, set busy=0, return to IDLE.
- Latency: accept edge E0, result written at edge E(WIDTH+1). busy is high for WIDTH+1 cycles, and done is high in the cycle after E(WIDTH+1).
- Result mapping:
  - MULT/MULTU: HI = upper WIDTH bits of the product, LO = lower WIDTH bits.
  - DIV/DIVU: LO = quotient, HI = remainder.
- Divide by zero: LO = all ones, HI = dividend (unmodified Rdata1), div_zero=1. Any completed MULT/DIV with a nonzero divisor clears div_zero. Timing is the same as a normal divide.
- Signed overflow (DIV of -2^(WIDTH-1) by -1): LO = -2^(WIDTH-1), HI = 0, no flag.
- cancel=1 in CALC or FIX: go to IDLE at that edge. HI/LO and div_zero are unchanged, done stays 0, busy=0 the next cycle. cancel has priority over the FIX write.
- start while busy=1 (any op, including MTHI/MTLO) is ignored; the issuing stage must hold it.
- HIreg/LOreg hold their old values throughout CALC and change only at the FIX edge, at an MTHI/MTLO accept, or at reset.

Test Plan:
1. Signed multiply: MULT, Rdata1=FFFFFFFD, Rdata2=00000005 → busy for 33 cycles, done pulse, HI=FFFFFFFF, LO=FFFFFFF1.
2. Unsigned multiply: MULTU, FFFFFFFF × FFFFFFFF → HI=FFFFFFFE, LO=00000001; a second start issued while busy is ignored (results unchanged, no extra done).
3. Signed divide: DIV, FFFFFFF9 / 00000002 → LO=FFFFFFFD, HI=FFFFFFFF. Then DIV 80000000 / FFFFFFFF → LO=80000000, HI=00000000.
4. Divide by zero: DIVU 00000064 / 0 → LO=FFFFFFFF, HI=00000064, div_zero=1. A following MULTU 2×3 → HI=0, LO=6, div_zero=0.
5. Cancel: HI/LO preloaded to 11111111/22222222 via MTHI/MTLO (each takes 1 cycle, no busy). MULT 7×7 issued, cancel asserted at CALC cycle 10 → busy=0 next cycle, no done, HI/LO still 11111111/22222222.
6. Reset mid-operation: RST=0 during CALC of a DIVU → next cycle busy=0, done=0, HI=LO=0, div_zero=0; after RST=1, a new MULTU 5×5 completes with LO=00000019.
